// File: rtl/truth_table_scanner.sv
// Exhaustive truth-table scanner for a 5-input, 1-output combinational unit.
// Sweeps all 32 input vectors, samples F after a settle time and compares the result against EXPECTED.
module truth_table_scanner #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter logic [31:0] EXPECTED      = 32'h9669_6996
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        f_in,
   output logic [4:0]  vec_out,
   output logic        busy,
   output logic        done,
   output logic [31:0] table_out,
   output logic [5:0]  mismatch_cnt,
   output logic        pass,
   output logic [4:0]  first_fail
);

   localparam int unsigned VEC_W   = 5;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned MCNT_W  = 6;
   localparam int unsigned NUM_VEC = 32;

   localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VEC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   // Settle time must fit the 8-bit counter and cover at least one cycle.
   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("truth_table_scanner: SETTLE_CYCLES must be in 1..255");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   settle_cnt;
   logic               fail_seen;

   logic               miss_c;
   logic [MCNT_W-1:0]  mismatch_next_c;

   // Compare the sampled output against the golden table for the current vector.
   assign miss_c          = f_in ^ EXPECTED[vec_out];
   assign mismatch_next_c = mismatch_cnt + MCNT_W'(miss_c);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         vec_out      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         table_out    <= '0;
         mismatch_cnt <= '0;
         pass         <= 1'b0;
         first_fail   <= '0;
         settle_cnt   <= '0;
         fail_seen    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               // A new scan wipes all previous results on the launching edge.
               if (start) begin
                  state        <= SETTLE;
                  vec_out      <= '0;
                  settle_cnt   <= '0;
                  table_out    <= '0;
                  mismatch_cnt <= '0;
                  first_fail   <= '0;
                  fail_seen    <= 1'b0;
                  done         <= 1'b0;
                  pass         <= 1'b0;
                  busy         <= 1'b1;
               end
            end

            SETTLE: begin
               settle_cnt <= settle_cnt + CNT_W'(1);
               if (settle_cnt == SETTLE_LAST) begin
                  state <= SAMPLE;
               end
            end

            SAMPLE: begin
               table_out[vec_out] <= f_in;
               mismatch_cnt       <= mismatch_next_c;
               if (miss_c && !fail_seen) begin
                  first_fail <= vec_out;
                  fail_seen  <= 1'b1;
               end
               // Vector 31 is terminal; vec_out never wraps within a scan.
               if (vec_out == LAST_VEC) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (mismatch_next_c == '0);
               end else begin
                  vec_out    <= vec_out + VEC_W'(1);
                  settle_cnt <= '0;
                  state      <= SETTLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Randomized self-checking bench for truth_table_scanner.
// The unit under test is modelled as 5-input parity with a per-vector fault mask.
module tb_truth_table_scanner;

   localparam int unsigned SC       = 4;
   localparam logic [31:0] EXP_TAB  = 32'h9669_6996;
   localparam int unsigned PER_VEC  = SC + 1;
   localparam int unsigned SCAN_LEN = 32 * PER_VEC;

   logic        clk;
   logic        rst;
   logic        start;
   logic        f_in;
   logic [4:0]  vec_out;
   logic        busy;
   logic        done;
   logic [31:0] table_out;
   logic [5:0]  mismatch_cnt;
   logic        pass;
   logic [4:0]  first_fail;

   logic [31:0] fault_mask;

   int n_checks;
   int n_errors;

   truth_table_scanner #(
      .SETTLE_CYCLES (SC),
      .EXPECTED      (EXP_TAB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .f_in         (f_in),
      .vec_out      (vec_out),
      .busy         (busy),
      .done         (done),
      .table_out    (table_out),
      .mismatch_cnt (mismatch_cnt),
      .pass         (pass),
      .first_fail   (first_fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational unit under test: parity of A..E, inverted where the fault mask is set.
   assign f_in = (^vec_out) ^ fault_mask[vec_out];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Truth table the scanner should observe for a given fault mask.
   function automatic logic [31:0] ref_table(input logic [31:0] mask);
      logic [31:0] t;
      for (int v = 0; v < 32; v++) begin
         t[v] = logic'($countones(5'(v)) % 2) ^ mask[v];
      end
      return t;
   endfunction

   function automatic int ref_first_fail(input logic [31:0] diff);
      int ff;
      ff = 0;
      for (int v = 31; v >= 0; v--) begin
         if (diff[v]) ff = v;
      end
      return ff;
   endfunction

   task automatic check_results(input string tag, input logic [31:0] mask);
      logic [31:0] t;
      logic [31:0] diff;
      int          cnt;
      t    = ref_table(mask);
      diff = t ^ EXP_TAB;
      cnt  = $countones(diff);
      chk({tag, ".table"},      table_out,           t);
      chk({tag, ".mismatch"},   32'(mismatch_cnt),   32'(cnt));
      chk({tag, ".first_fail"}, 32'(first_fail),     32'(ref_first_fail(diff)));
      chk({tag, ".pass"},       32'(pass),           32'(cnt == 0));
      chk({tag, ".done"},       32'(done),           32'd1);
      chk({tag, ".busy"},       32'(busy),           32'd0);
      chk({tag, ".vec_last"},   32'(vec_out),        32'd31);
   endtask

   // Launch one scan and track vec_out/busy/done every cycle; optional stray start at repulse_n.
   task automatic run_scan(input string tag, input logic [31:0] mask, input int repulse_n);
      fault_mask = mask;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({tag, ".launch_busy"},  32'(busy),         32'd1);
      chk({tag, ".launch_done"},  32'(done),         32'd0);
      chk({tag, ".launch_table"}, table_out,         32'd0);
      chk({tag, ".launch_mcnt"},  32'(mismatch_cnt), 32'd0);
      chk({tag, ".launch_vec"},   32'(vec_out),      32'd0);
      for (int n = 1; n <= int'(SCAN_LEN); n++) begin
         @(posedge clk);
         #1;
         start = (n == repulse_n);
         if (n < int'(SCAN_LEN)) begin
            chk({tag, ".vec"},  32'(vec_out), 32'(n / int'(PER_VEC)));
            chk({tag, ".busy"}, 32'(busy),    32'd1);
            chk({tag, ".done"}, 32'(done),    32'd0);
         end
      end
      start = 1'b0;
      check_results(tag, mask);
      // Results must hold while idle in DONE.
      repeat (3) @(posedge clk);
      #1;
      check_results({tag, ".hold"}, mask);
   endtask

   initial begin
      logic [31:0] m;
      n_checks   = 0;
      n_errors   = 0;
      start      = 1'b0;
      fault_mask = '0;
      rst        = 1'b1;

      // Reset and idle behaviour.
      repeat (3) @(posedge clk);
      #1;
      chk("rst.vec",   32'(vec_out), 32'd0);
      chk("rst.busy",  32'(busy),    32'd0);
      chk("rst.done",  32'(done),    32'd0);
      chk("rst.table", table_out,    32'd0);
      chk("rst.pass",  32'(pass),    32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("idle.vec",   32'(vec_out),      32'd0);
      chk("idle.busy",  32'(busy),         32'd0);
      chk("idle.done",  32'(done),         32'd0);
      chk("idle.mcnt",  32'(mismatch_cnt), 32'd0);
      chk("idle.ff",    32'(first_fail),   32'd0);

      // Directed fault patterns, then randomized ones with random stray starts.
      run_scan("clean",   32'h0000_0000, -1);
      run_scan("tied0",   EXP_TAB,       -1);
      run_scan("v29",     32'h2000_0000, -1);
      run_scan("repulse", 32'h0000_0000, 7 * int'(PER_VEC) + 2);
      run_scan("all_bad", 32'hFFFF_FFFF, -1);
      run_scan("v31",     32'h8000_0000, -1);
      for (int i = 0; i < 6; i++) begin
         m = (i % 2 == 0) ? $urandom : ($urandom & $urandom & $urandom);
         run_scan($sformatf("rand%0d", i), m, int'($urandom_range(1, SCAN_LEN - 2)));
      end

      // Asynchronous reset while vector 10 is being driven.
      fault_mask = '0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10 * PER_VEC) @(posedge clk);
      #1;
      chk("abort.vec10", 32'(vec_out), 32'd10);
      #2;
      rst = 1'b1;
      #1;
      chk("abort.vec",   32'(vec_out),      32'd0);
      chk("abort.busy",  32'(busy),         32'd0);
      chk("abort.table", table_out,         32'd0);
      chk("abort.mcnt",  32'(mismatch_cnt), 32'd0);
      chk("abort.done",  32'(done),         32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("abort.idle_busy", 32'(busy), 32'd0);
      run_scan("post_abort", 32'h0000_0000, -1);

      // start held high: one scan, then an immediate re-trigger from DONE.
      m = $urandom;
      fault_mask = m;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      repeat (SCAN_LEN - 1) @(posedge clk);
      #1;
      chk("held.not_yet_done", 32'(done), 32'd0);
      @(posedge clk);
      #1;
      check_results("held", m);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("held.retrig_busy",  32'(busy),         32'd1);
      chk("held.retrig_done",  32'(done),         32'd0);
      chk("held.retrig_table", table_out,         32'd0);
      chk("held.retrig_mcnt",  32'(mismatch_cnt), 32'd0);
      chk("held.retrig_pass",  32'(pass),         32'd0);
      repeat (SCAN_LEN) @(posedge clk);
      #1;
      check_results("held2", m);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Absolute time bound so the bench always terminates.
   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1, "timeout");
   end

endmodule
